// File: rtl/mrx_line_sched.sv
// rtl/mrx_line_sched.sv - MRX line-buffer slot scheduler (writer/reader slot tracking, prime/run FSM)
// Optional error counters: MRX_LINE_SCHED_ERRCNT_EN
module mrx_line_sched #(
  parameter int BANK_AW     = 2,
  parameter int PRIME_LINES = 1
) (
  input  logic               PCK,
  input  logic               RSTN,
  input  logic               SCHED_EN,
  input  logic               FRAME_ST,
  input  logic               WR_LINE_DONE,
  input  logic               RD_LINE_REQ,
  input  logic               RD_LINE_END,
  output logic [BANK_AW-1:0] WR_SLOT,
  output logic [BANK_AW-1:0] RD_SLOT,
  output logic               RD_GO,
  output logic               RD_BLANK,
  output logic [BANK_AW:0]   LVL,
  output logic [1:0]         STATE,
  output logic [7:0]         OVF_CNT,
  output logic [7:0]         UNF_CNT
);

  localparam int NSLOT = 1 << BANK_AW;
  // One slot is always reserved for the writer, and one more while the reader holds a line.
  localparam logic [BANK_AW+1:0] WR_LIMIT = (BANK_AW+2)'(NSLOT - 2);
  localparam logic [BANK_AW:0]   PRIME_LV = (BANK_AW+1)'(PRIME_LINES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t               state;
  logic [BANK_AW-1:0]   rp;
  logic                 rd_busy;
  logic                 active;
  logic [BANK_AW+1:0]   occ;
  logic                 wr_room;
  logic                 wr_accept;
  logic                 rd_take;
  logic                 rd_blank_nxt;

  assign STATE        = state;
  assign active       = (state == ST_PRIME) || (state == ST_RUN);
  assign occ          = {1'b0, LVL} + {{(BANK_AW+1){1'b0}}, rd_busy};
  assign wr_room      = (occ <= WR_LIMIT);
  assign wr_accept    = active && WR_LINE_DONE && wr_room;
  assign rd_take      = (state == ST_RUN) && RD_LINE_REQ && (LVL != '0);
  assign rd_blank_nxt = active && RD_LINE_REQ && !rd_take;

  always_ff @(posedge PCK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= ST_IDLE;
      WR_SLOT  <= '0;
      RD_SLOT  <= '0;
      rp       <= '0;
      LVL      <= '0;
      rd_busy  <= 1'b0;
      RD_GO    <= 1'b0;
      RD_BLANK <= 1'b0;
    end else if (!SCHED_EN) begin
      state    <= ST_IDLE;
      WR_SLOT  <= '0;
      RD_SLOT  <= '0;
      rp       <= '0;
      LVL      <= '0;
      rd_busy  <= 1'b0;
      RD_GO    <= 1'b0;
      RD_BLANK <= 1'b0;
    end else if (FRAME_ST) begin
      state    <= ST_PRIME;
      WR_SLOT  <= '0;
      rp       <= '0;
      LVL      <= '0;
      rd_busy  <= 1'b0;
      RD_GO    <= 1'b0;
      RD_BLANK <= 1'b0;
    end else begin
      RD_GO    <= rd_take;
      RD_BLANK <= rd_blank_nxt;
      if (wr_accept)
        WR_SLOT <= WR_SLOT + BANK_AW'(1);
      if (rd_take) begin
        RD_SLOT <= rp;
        rp      <= rp + BANK_AW'(1);
      end
      if (wr_accept && !rd_take)
        LVL <= LVL + (BANK_AW+1)'(1);
      else if (!wr_accept && rd_take)
        LVL <= LVL - (BANK_AW+1)'(1);
      // A blank grant leaves the reader's previous line marked busy.
      if (rd_take)
        rd_busy <= 1'b1;
      else if (active && RD_LINE_END)
        rd_busy <= 1'b0;
      if (state == ST_PRIME && LVL >= PRIME_LV)
        state <= ST_RUN;
    end
  end

`ifdef MRX_LINE_SCHED_ERRCNT_EN
  logic wr_drop;
  logic unf_evt;

  assign wr_drop = active && WR_LINE_DONE && !wr_room;
  assign unf_evt = (state == ST_RUN) && RD_LINE_REQ && (LVL == '0);

  always_ff @(posedge PCK or negedge RSTN) begin
    if (!RSTN) begin
      OVF_CNT <= 8'd0;
      UNF_CNT <= 8'd0;
    end else if (!SCHED_EN || FRAME_ST) begin
      OVF_CNT <= 8'd0;
      UNF_CNT <= 8'd0;
    end else begin
      if (wr_drop && OVF_CNT != 8'hFF)
        OVF_CNT <= OVF_CNT + 8'd1;
      if (unf_evt && UNF_CNT != 8'hFF)
        UNF_CNT <= UNF_CNT + 8'd1;
    end
  end
`else
  assign OVF_CNT = 8'd0;
  assign UNF_CNT = 8'd0;
`endif

endmodule

// File: doc/mrx_line_sched.md
# mrx_line_sched

Line-slot scheduler for the MRX line buffer in the PCK domain. Tracks which buffer slot the MIPI writer fills and which completed slot the output timing reads. Detects overflow (writer laps reader) and underflow (no line ready at read time), and drives a priming/run state machine per frame. Sits between the synchronized MIPI line/frame events and the read-side timing generator that owns the SRAM read port.

## Interface
Parameters:
- BANK_AW, 2: slot index width. NSLOT = 2^BANK_AW slots, each one full line.
- PRIME_LINES, 1: completed lines required before reads are served. Legal range 1..NSLOT-2.

Ports:
- PCK  in  1  pixel clock; the only clock.
- RSTN  in  1  asynchronous, active-low reset.
- SCHED_EN  in  1  register enable. Low forces IDLE and clears all state.
- FRAME_ST  in  1  1-cycle pulse, frame start (VSYNC rising edge, already synchronized to PCK).
- WR_LINE_DONE  in  1  1-cycle pulse, writer finished the line in WR_SLOT.
- RD_LINE_REQ  in  1  1-cycle pulse, output timing starts an active line.
- RD_LINE_END  in  1  1-cycle pulse, reader finished RD_SLOT.
- WR_SLOT  out  BANK_AW  slot currently being written.
- RD_SLOT  out  BANK_AW  slot granted to the reader.
- RD_GO  out  1  1-cycle pulse, line granted in RD_SLOT.
- RD_BLANK  out  1  1-cycle pulse, no line granted; reader outputs blank.
- LVL  out  BANK_AW+1  completed, unread lines.
- STATE  out  2  0=IDLE, 1=PRIME, 2=RUN.
- OVF_CNT  out  8  dropped-line count.
- UNF_CNT  out  8  blank-line count.

## Operation
- Internal state: WR_SLOT, rd pointer RP (oldest completed slot), LVL, RD_BUSY flag, STATE. Pointers wrap modulo NSLOT.
- Input priority, highest first: SCHED_EN=0, then FRAME_ST, then the line events.
- SCHED_EN=0 forces STATE=IDLE and zeroes every register.
- FRAME_ST (with SCHED_EN=1), from any state, sets STATE=PRIME and WR_SLOT=RP=LVL=RD_BUSY=0, and clears both counters. Line events in the same cycle are ignored.
- IDLE is exited only by FRAME_ST. In IDLE, all line events are ignored.
- PRIME moves to RUN on the first cycle with registered LVL ≥ PRIME_LINES. RUN persists until FRAME_ST or SCHED_EN=0.
- Write accept (PRIME or RUN):
  - Condition: WR_LINE_DONE and LVL+RD_BUSY ≤ NSLOT-2.
  - Effect: WR_SLOT+1 and LVL+1.
  - Otherwise overflow: WR_SLOT and LVL are held, the line is overwritten, and OVF_CNT increments.
- RD_LINE_END clears RD_BUSY.
- RD_LINE_REQ with RD_BUSY=1 implicitly ends the previous line first.
- RD_LINE_REQ in RUN with LVL>0:
  - RD_SLOT←RP, RP+1, LVL-1, RD_BUSY←1, RD_GO pulse.
- RD_LINE_REQ in RUN with LVL=0:
  - RD_BLANK pulse and UNF_CNT+1.
  - RD_SLOT and RD_BUSY hold their values; RD_BUSY is not cleared by RD_BLANK.
- RD_LINE_REQ in PRIME: RD_BLANK pulse only, no counter change.
- Read and write decisions in the same cycle both use registered (pre-edge) LVL and RD_BUSY.
  - Next LVL = LVL + accept - take.
  - At full, a simultaneous read does not rescue the write; it is counted as an overflow.
- Counters saturate at 255.

## Timing
- All outputs registered.
- Reset value of every output is 0 (STATE=IDLE).
- RD_GO/RD_BLANK are asserted the cycle after RD_LINE_REQ, exactly 1 cycle wide. RD_SLOT is valid in the same cycle as RD_GO.
- WR_SLOT, LVL and counters update the cycle after the causing pulse.
- PRIME→RUN: STATE reads 2 one cycle after LVL reaches PRIME_LINES, i.e. 2 cycles after the accepting WR_LINE_DONE.
- Back-to-back pulses on consecutive cycles are each processed.
- RSTN assertion mid-line returns everything to reset values immediately (asynchronous).

## Configuration
- Macro: MRX_LINE_SCHED_ERRCNT_EN.
- Defined: OVF_CNT/UNF_CNT are 8-bit saturating counters as above.
- Undefined: counter logic is not compiled. OVF_CNT and UNF_CNT are tied to 0. Overflow and underflow behaviour on slots, LVL and RD_BLANK is unchanged.

## Test plan
All scenarios use BANK_AW=2 (NSLOT=4), PRIME_LINES=1, SCHED_EN=1.
- Prime: reset, FRAME_ST, one WR_LINE_DONE → WR_SLOT=1, LVL=1, STATE=2 two cycles later. Then RD_LINE_REQ → RD_GO, RD_SLOT=0, LVL=0.
- Overflow: after FRAME_ST, 4 WR_LINE_DONE with no reads → first 3 accepted (LVL=3, WR_SLOT=3). The 4th gives OVF_CNT=1, WR_SLOT=3, LVL=3.
- Underflow: RUN with LVL=0, RD_LINE_REQ → RD_BLANK pulse, RD_GO=0, UNF_CNT=1, RD_SLOT unchanged.
- Simultaneous: LVL=1 and RP=0; WR_LINE_DONE and RD_LINE_REQ in the same cycle → RD_GO with RD_SLOT=0, WR_SLOT advances by 1, LVL stays 1.
- Saturation/flush: 300 underflow requests → UNF_CNT=255. FRAME_ST → UNF_CNT=0, STATE=1, WR_SLOT=0, LVL=0.
- Disable/macro: with the macro undefined, repeat the underflow scenario → UNF_CNT stays 0. Then drive SCHED_EN=0 in RUN → STATE=0 and all outputs 0 next cycle.
